// File: rtl/router_4x4_pkg.sv
// router_4x4_pkg: shared widths, CSR map, input-buffer states and the
// round-robin pick used by every output arbiter.
package router_4x4_pkg;
  localparam int DATA_W    = 8;
  localparam int BUF_DEPTH = 64;
  localparam int NPORTS    = 4;
  localparam int CSR_AW    = 8;
  localparam int CSR_DW    = 32;
  localparam int PW        = $clog2(NPORTS);
  localparam int AW        = $clog2(BUF_DEPTH);
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam logic [CSR_AW-1:0] A_CTRL = 'h00;
  localparam logic [CSR_AW-1:0] A_RX   = 'h10;
  localparam logic [CSR_AW-1:0] A_TX   = 'h20;
  localparam logic [CSR_AW-1:0] A_DROP = 'h30;

  typedef enum logic [1:0] {IDLE, RECV, HOLD, SEND} in_state_e;

  // Returns {found, index}; the input right after `last` has top priority.
  function automatic logic [PW:0] rr_pick(input logic [NPORTS-1:0] req, input logic [PW-1:0] last);
    logic [PW-1:0] i;
    rr_pick = '0;
    for (int k = NPORTS; k >= 1; k--) begin
      i = last + PW'(k);
      if (req[i]) rr_pick = {1'b1, i};
    end
  endfunction
endpackage

// File: rtl/router_4x4_in_port.sv
// router_4x4_in_port: single-packet store-and-forward buffer with framing,
// legality checks, request/grant handshake and rx/drop pulses.
module router_4x4_in_port
  import router_4x4_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              en_i,
  input  logic [DATA_W-1:0] sa_i,
  input  logic              sa_valid_i,
  input  logic              gnt_i,
  output logic              req_o,
  output logic [DATA_W-1:0] dest_o,
  output logic [DATA_W-1:0] tx_data_o,
  output logic              last_o,
  output logic              rx_o,
  output logic              drop_o
);
  in_state_e         state_q, state_d;
  logic [DATA_W-1:0] mem_q [BUF_DEPTH];
  logic [CNT_W-1:0]  len_q, len_d, ptr_q, ptr_d;
  logic [DATA_W-1:0] dest_q, dest_d;
  logic [AW-1:0]     waddr;
  logic              v_q, skip_q, skip_d, over_q, over_d, rx_q, drop_q;
  logic              rise, take, legal, wen;

  always_comb begin
    rise = sa_valid_i & ~v_q;
    take = rise & en_i & (state_q == IDLE);
    legal = ~over_q & (len_q >= CNT_W'(2)) & (dest_q != '0) & (dest_q <= DATA_W'(NPORTS));
    wen = take | ((state_q == RECV) & sa_valid_i & (len_q != CNT_W'(BUF_DEPTH)));
    waddr = take ? '0 : len_q[AW-1:0];
    last_o = (state_q == SEND) & (ptr_q == len_q - CNT_W'(1));
    // A packet that cannot be taken is swallowed until its valid falls.
    skip_d = rise ? ~take : skip_q & sa_valid_i;
    state_d = state_q;
    len_d = len_q;
    ptr_d = ptr_q;
    dest_d = dest_q;
    over_d = over_q;
    case (state_q)
      IDLE: if (take) begin
        state_d = RECV;
        len_d = CNT_W'(1);
        dest_d = sa_i;
        over_d = 1'b0;
      end
      RECV: if (!sa_valid_i) state_d = legal ? HOLD : IDLE;
        else if (len_q == CNT_W'(BUF_DEPTH)) over_d = 1'b1;
        else len_d = len_q + CNT_W'(1);
      HOLD: if (gnt_i) begin
        state_d = SEND;
        ptr_d = '0;
      end
      SEND: begin
        ptr_d = ptr_q + CNT_W'(1);
        if (last_o) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      len_q <= '0;
      ptr_q <= '0;
      dest_q <= '0;
      v_q <= 1'b0;
      skip_q <= 1'b0;
      over_q <= 1'b0;
      rx_q <= 1'b0;
      drop_q <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q <= len_d;
      ptr_q <= ptr_d;
      dest_q <= dest_d;
      v_q <= sa_valid_i;
      skip_q <= skip_d;
      over_q <= over_d;
      rx_q <= (state_q == RECV) & ~sa_valid_i & legal;
      drop_q <= ((state_q == RECV) & ~sa_valid_i & ~legal) | (skip_q & ~sa_valid_i);
    end
  end

  always_ff @(posedge clk_i) if (wen) mem_q[waddr] <= sa_i;

  assign req_o = state_q == HOLD;
  assign dest_o = dest_q;
  assign tx_data_o = mem_q[ptr_q[AW-1:0]];
  assign rx_o = rx_q;
  assign drop_o = drop_q;
endmodule

// File: rtl/router_4x4.sv
// router_4x4: four-port packet router with per-output round-robin arbiters,
// registered output muxes and a CSR block with per-port counters.
module router_4x4
  import router_4x4_pkg::*;
(
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic [DATA_W-1:0] sa1_i,
  input  logic [DATA_W-1:0] sa2_i,
  input  logic [DATA_W-1:0] sa3_i,
  input  logic [DATA_W-1:0] sa4_i,
  input  logic              sa1_valid_i,
  input  logic              sa2_valid_i,
  input  logic              sa3_valid_i,
  input  logic              sa4_valid_i,
  output logic [DATA_W-1:0] da1_o,
  output logic [DATA_W-1:0] da2_o,
  output logic [DATA_W-1:0] da3_o,
  output logic [DATA_W-1:0] da4_o,
  output logic              da1_valid_o,
  output logic              da2_valid_o,
  output logic              da3_valid_o,
  output logic              da4_valid_o,
  input  logic              wr_i,
  input  logic              rd_i,
  input  logic [CSR_AW-1:0] addr_i,
  input  logic [CSR_DW-1:0] wdata_i,
  output logic [CSR_DW-1:0] rdata_o
);
  logic [NPORTS-1:0][DATA_W-1:0] sa, dest, txd, da_q;
  logic [NPORTS-1:0]             sv, req, gnt, last, rxp, drp, busy_q, dv_q, done;
  logic [NPORTS-1:0][NPORTS-1:0] oreq;
  logic [NPORTS-1:0][PW:0]       pick;
  logic [NPORTS-1:0][PW-1:0]     last_q;
  logic [NPORTS-1:0][CSR_DW-1:0] rx_q, tx_q, dr_q;
  logic [CSR_DW-1:0]             rdata_q, rmux;
  logic                          en_q, clr, unused_wdata;

  assign sa = {sa4_i, sa3_i, sa2_i, sa1_i};
  assign sv = {sa4_valid_i, sa3_valid_i, sa2_valid_i, sa1_valid_i};
  assign {da4_o, da3_o, da2_o, da1_o} = da_q;
  assign {da4_valid_o, da3_valid_o, da2_valid_o, da1_valid_o} = dv_q;
  assign rdata_o = rdata_q;
  assign clr = wr_i & (addr_i == A_CTRL) & wdata_i[1];
  assign unused_wdata = ^wdata_i[CSR_DW-1:2];

  for (genvar p = 0; p < NPORTS; p++) begin : g_in
    router_4x4_in_port u_in (
      .clk_i(clk_i),
      .reset_i(reset_i),
      .en_i(en_q),
      .sa_i(sa[p]),
      .sa_valid_i(sv[p]),
      .gnt_i(gnt[p]),
      .req_o(req[p]),
      .dest_o(dest[p]),
      .tx_data_o(txd[p]),
      .last_o(last[p]),
      .rx_o(rxp[p]),
      .drop_o(drp[p])
    );
  end

  // last_q doubles as the current owner while an output is busy.
  always_comb begin
    oreq = '0;
    pick = '0;
    gnt = '0;
    done = '0;
    for (int m = 0; m < NPORTS; m++) begin
      for (int i = 0; i < NPORTS; i++) oreq[m][i] = req[i] & (dest[i] == DATA_W'(m + 1));
      pick[m] = rr_pick(oreq[m], last_q[m]);
      if (!busy_q[m] && pick[m][PW]) gnt[pick[m][PW-1:0]] = 1'b1;
      done[m] = busy_q[m] & last[last_q[m]];
    end
  end

  always_comb begin
    rmux = '0;
    if (addr_i == A_CTRL) rmux = CSR_DW'(en_q);
    for (int i = 0; i < NPORTS; i++) begin
      if (addr_i == A_RX + CSR_AW'(i)) rmux = rx_q[i];
      if (addr_i == A_TX + CSR_AW'(i)) rmux = tx_q[i];
      if (addr_i == A_DROP + CSR_AW'(i)) rmux = dr_q[i];
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      busy_q <= '0;
      last_q <= '1;
      dv_q <= '0;
      da_q <= '0;
      rx_q <= '0;
      tx_q <= '0;
      dr_q <= '0;
      en_q <= 1'b1;
      rdata_q <= '0;
    end else begin
      for (int m = 0; m < NPORTS; m++) begin
        dv_q[m] <= busy_q[m];
        da_q[m] <= busy_q[m] ? txd[last_q[m]] : '0;
        if (busy_q[m] ? done[m] : pick[m][PW]) busy_q[m] <= ~busy_q[m];
        if (!busy_q[m] && pick[m][PW]) last_q[m] <= pick[m][PW-1:0];
        rx_q[m] <= clr ? '0 : rx_q[m] + CSR_DW'(rxp[m]);
        tx_q[m] <= clr ? '0 : tx_q[m] + CSR_DW'(done[m]);
        dr_q[m] <= clr ? '0 : dr_q[m] + CSR_DW'(drp[m]);
      end
      if (wr_i && addr_i == A_CTRL) en_q <= wdata_i[0];
      if (rd_i) rdata_q <= rmux;
    end
  end
endmodule

// File: tb/tb_router_4x4.sv
// tb_router_4x4: directed self-checking bench for router_4x4.
module tb_router_4x4;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  sa [4];
  logic [7:0]  da [4];
  logic        sv [4];
  logic        dv [4];
  logic        pdv [4];
  logic        wr = 1'b0, rd = 1'b0;
  logic [7:0]  addr = '0;
  logic [31:0] wdata = '0, rdata, rv;
  logic [7:0]  pk [4][$];
  logic [8:0]  cap [4][$];
  logic [8:0]  ex [$];
  int n_cmp = 0, n_err = 0;

  always #5 clk = ~clk;

  router_4x4 dut (
    .clk_i(clk), .reset_i(reset),
    .sa1_i(sa[0]), .sa2_i(sa[1]), .sa3_i(sa[2]), .sa4_i(sa[3]),
    .sa1_valid_i(sv[0]), .sa2_valid_i(sv[1]), .sa3_valid_i(sv[2]), .sa4_valid_i(sv[3]),
    .da1_o(da[0]), .da2_o(da[1]), .da3_o(da[2]), .da4_o(da[3]),
    .da1_valid_o(dv[0]), .da2_valid_o(dv[1]), .da3_valid_o(dv[2]), .da4_valid_o(dv[3]),
    .wr_i(wr), .rd_i(rd), .addr_i(addr), .wdata_i(wdata), .rdata_o(rdata)
  );

  // Output streams: {1,byte} per valid byte, {0,00} for each idle gap after a packet.
  always @(negedge clk)
    for (int m = 0; m < 4; m++) begin
      if (dv[m]) cap[m].push_back({1'b1, da[m]});
      else if (pdv[m] === 1'b1) cap[m].push_back(9'h000);
      pdv[m] <= dv[m];
    end

  task automatic clr_cap;
    for (int m = 0; m < 4; m++) cap[m].delete();
    ex.delete();
  endtask

  task automatic mk(input int p, input int d, input int n, input int base);
    pk[p].delete();
    pk[p].push_back(8'(d));
    for (int i = 1; i < n; i++) pk[p].push_back(8'(base + i));
  endtask

  task automatic ex_add(input int p);
    for (int i = 0; i < pk[p].size(); i++) ex.push_back({1'b1, pk[p][i]});
    ex.push_back(9'h000);
  endtask

  task automatic send(input logic [3:0] m);
    int n = 0;
    for (int p = 0; p < 4; p++) if (m[p] && pk[p].size() > n) n = pk[p].size();
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      for (int p = 0; p < 4; p++) if (m[p]) begin sa[p] = pk[p][i]; sv[p] = 1'b1; end
    end
    @(negedge clk);
    for (int p = 0; p < 4; p++) if (m[p]) begin sa[p] = '0; sv[p] = 1'b0; end
  endtask

  task automatic csr_read(input logic [7:0] a, output logic [31:0] d);
    @(negedge clk); addr = a; rd = 1'b1;
    @(negedge clk); rd = 1'b0;
    d = rdata;
  endtask

  task automatic csr_write(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk); addr = a; wdata = d; wr = 1'b1;
    @(negedge clk); wr = 1'b0;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      n_cmp++;
      if (dv[m] !== 1'b0 || da[m] !== 8'h00) begin n_err++; $display("FAIL reset_da%0d: got valid=%b data=%h, expected 0/00", m + 1, dv[m], da[m]); end
    end
    n_cmp++;
    if (rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
    reset = 1'b0;
    csr_read(8'h00, rv); n_cmp++;
    if (rv !== 32'h1) begin n_err++; $display("FAIL reset_ctrl: got %h expected 1", rv); end
    csr_read(8'h10, rv); n_cmp++;
    if (rv !== 32'h0) begin n_err++; $display("FAIL reset_rx1: got %h expected 0", rv); end
  endtask

  task automatic test_single;
    logic       exv;
    logic [7:0] exd;
    clr_cap();
    pk[0].delete(); pk[0].push_back(8'h03); pk[0].push_back(8'hAA); pk[0].push_back(8'h55);
    send(4'b0001);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      exv = k >= 2 && k <= 4;
      exd = k == 2 ? 8'h03 : k == 3 ? 8'hAA : 8'h55;
      n_cmp++;
      if (dv[2] !== exv || (exv && da[2] !== exd)) begin
        n_err++; $display("FAIL single_cyc%0d: got valid=%b data=%h, expected valid=%b data=%h", k, dv[2], da[2], exv, exd);
      end
    end
    csr_read(8'h10, rv); n_cmp++;
    if (rv !== 32'd1) begin n_err++; $display("FAIL single_rx1: got %0d expected 1", rv); end
    csr_read(8'h22, rv); n_cmp++;
    if (rv !== 32'd1) begin n_err++; $display("FAIL single_tx3: got %0d expected 1", rv); end
  endtask

  task automatic test_contention;
    clr_cap();
    mk(0, 4, 4, 8'h0F); mk(1, 4, 4, 8'h1F);
    ex_add(0); ex_add(1);
    send(4'b0011);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (cap[3].size() != ex.size()) begin n_err++; $display("FAIL cont1_len: got %0d entries expected %0d", cap[3].size(), ex.size()); end
    for (int i = 0; i < ex.size() && i < cap[3].size(); i++) begin
      n_cmp++;
      if (cap[3][i] !== ex[i]) begin n_err++; $display("FAIL cont1[%0d]: got %h expected %h", i, cap[3][i], ex[i]); end
    end
    mk(0, 4, 3, 8'h2F);
    send(4'b0001);
    repeat (10) @(negedge clk);
    clr_cap();
    mk(0, 4, 3, 8'h3F); mk(1, 4, 3, 8'h4F);
    ex_add(1); ex_add(0);
    send(4'b0011);
    repeat (20) @(negedge clk);
    n_cmp++;
    if (cap[3].size() != ex.size()) begin n_err++; $display("FAIL cont2_len: got %0d entries expected %0d", cap[3].size(), ex.size()); end
    for (int i = 0; i < ex.size() && i < cap[3].size(); i++) begin
      n_cmp++;
      if (cap[3][i] !== ex[i]) begin n_err++; $display("FAIL cont2[%0d]: got %h expected %h", i, cap[3][i], ex[i]); end
    end
    csr_read(8'h23, rv); n_cmp++;
    if (rv !== 32'd5) begin n_err++; $display("FAIL cont_tx4: got %0d expected 5", rv); end
  endtask

  task automatic test_illegal;
    clr_cap();
    mk(1, 0, 3, 8'h50); send(4'b0010);
    mk(1, 7, 3, 8'h50); send(4'b0010);
    mk(1, 1, 1, 8'h50); send(4'b0010);
    mk(1, 1, 65, 8'h50); send(4'b0010);
    repeat (10) @(negedge clk);
    for (int m = 0; m < 4; m++) begin
      n_cmp++;
      if (cap[m].size() != 0) begin n_err++; $display("FAIL illegal_da%0d: got %0d entries expected 0", m + 1, cap[m].size()); end
    end
    csr_read(8'h31, rv); n_cmp++;
    if (rv !== 32'd4) begin n_err++; $display("FAIL illegal_drop2: got %0d expected 4", rv); end
    clr_cap();
    mk(2, 1, 64, 8'h00); ex_add(2);
    send(4'b0100);
    repeat (72) @(negedge clk);
    n_cmp++;
    if (cap[0].size() != ex.size()) begin n_err++; $display("FAIL max_len: got %0d entries expected %0d", cap[0].size(), ex.size()); end
    for (int i = 0; i < ex.size() && i < cap[0].size(); i++) begin
      n_cmp++;
      if (cap[0][i] !== ex[i]) begin n_err++; $display("FAIL max[%0d]: got %h expected %h", i, cap[0][i], ex[i]); end
    end
  endtask

  task automatic test_back_to_back;
    clr_cap();
    mk(2, 1, 3, 8'h80); ex_add(2);
    send(4'b0100);
    mk(2, 1, 3, 8'h90);
    send(4'b0100);
    repeat (12) @(negedge clk);
    n_cmp++;
    if (cap[0].size() != ex.size()) begin n_err++; $display("FAIL b2b_len: got %0d entries expected %0d", cap[0].size(), ex.size()); end
    for (int i = 0; i < ex.size() && i < cap[0].size(); i++) begin
      n_cmp++;
      if (cap[0][i] !== ex[i]) begin n_err++; $display("FAIL b2b[%0d]: got %h expected %h", i, cap[0][i], ex[i]); end
    end
    csr_read(8'h32, rv); n_cmp++;
    if (rv !== 32'd1) begin n_err++; $display("FAIL b2b_drop3: got %0d expected 1", rv); end
  endtask

  task automatic test_disabled;
    clr_cap();
    csr_write(8'h00, 32'h0);
    mk(3, 2, 3, 8'h5F);
    send(4'b1000);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (cap[1].size() != 0) begin n_err++; $display("FAIL dis_da2: got %0d entries expected 0", cap[1].size()); end
    csr_read(8'h33, rv); n_cmp++;
    if (rv !== 32'd1) begin n_err++; $display("FAIL dis_drop4: got %0d expected 1", rv); end
    csr_write(8'h00, 32'h1);
    ex_add(3);
    send(4'b1000);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (cap[1].size() != ex.size()) begin n_err++; $display("FAIL en_len: got %0d entries expected %0d", cap[1].size(), ex.size()); end
    for (int i = 0; i < ex.size() && i < cap[1].size(); i++) begin
      n_cmp++;
      if (cap[1][i] !== ex[i]) begin n_err++; $display("FAIL en[%0d]: got %h expected %h", i, cap[1][i], ex[i]); end
    end
  endtask

  task automatic test_csr;
    @(negedge clk); addr = 8'h10; rd = 1'b1;
    @(negedge clk); rd = 1'b0; addr = 8'h20;
    n_cmp++;
    if (rdata !== 32'd4) begin n_err++; $display("FAIL csr_rd_lat: got %0d expected 4", rdata); end
    @(negedge clk); n_cmp++;
    if (rdata !== 32'd4) begin n_err++; $display("FAIL csr_rd_hold: got %0d expected 4", rdata); end
    csr_write(8'h10, 32'hFFFF);
    csr_read(8'h10, rv); n_cmp++;
    if (rv !== 32'd4) begin n_err++; $display("FAIL csr_ro: got %0d expected 4", rv); end
    @(negedge clk); addr = 8'h00; wdata = 32'h0; wr = 1'b1; rd = 1'b1;
    @(negedge clk); wr = 1'b0; rd = 1'b0;
    n_cmp++;
    if (rdata !== 32'h1) begin n_err++; $display("FAIL csr_wr_rd: got %h expected 1", rdata); end
    csr_read(8'h00, rv); n_cmp++;
    if (rv !== 32'h0) begin n_err++; $display("FAIL csr_ctrl0: got %h expected 0", rv); end
    csr_write(8'h00, 32'h3);
    for (int i = 0; i < 12; i++) begin
      csr_read(8'(8'h10 + 8'h10 * (i / 4) + i % 4), rv); n_cmp++;
      if (rv !== 32'h0) begin n_err++; $display("FAIL csr_clr_%0d: got %0d expected 0", i, rv); end
    end
    csr_read(8'h00, rv); n_cmp++;
    if (rv !== 32'h1) begin n_err++; $display("FAIL csr_ctrl1: got %h expected 1", rv); end
    csr_read(8'h50, rv); n_cmp++;
    if (rv !== 32'h0) begin n_err++; $display("FAIL csr_unmapped: got %h expected 0", rv); end
  endtask

  task automatic test_reset_mid;
    clr_cap();
    mk(0, 3, 20, 8'hA0);
    send(4'b0001);
    for (int k = 0; k < 20 && dv[2] !== 1'b1; k++) @(negedge clk);
    n_cmp++;
    if (dv[2] !== 1'b1) begin n_err++; $display("FAIL rmid_start: got valid=%b expected 1", dv[2]); end
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_cmp++;
    if (dv[2] !== 1'b0 || da[2] !== 8'h00) begin n_err++; $display("FAIL rmid_async: got valid=%b data=%h expected 0/00", dv[2], da[2]); end
    @(negedge clk); reset = 1'b0;
    csr_read(8'h10, rv); n_cmp++;
    if (rv !== 32'd0) begin n_err++; $display("FAIL rmid_rx1: got %0d expected 0", rv); end
    clr_cap();
    pk[0].delete(); pk[0].push_back(8'h03); pk[0].push_back(8'h77); pk[0].push_back(8'h88);
    ex_add(0);
    send(4'b0001);
    repeat (10) @(negedge clk);
    n_cmp++;
    if (cap[2].size() != ex.size()) begin n_err++; $display("FAIL rmid_len: got %0d entries expected %0d", cap[2].size(), ex.size()); end
    for (int i = 0; i < ex.size() && i < cap[2].size(); i++) begin
      n_cmp++;
      if (cap[2][i] !== ex[i]) begin n_err++; $display("FAIL rmid[%0d]: got %h expected %h", i, cap[2][i], ex[i]); end
    end
  endtask

  initial begin
    for (int p = 0; p < 4; p++) begin sa[p] = '0; sv[p] = 1'b0; end
    test_reset();
    test_single();
    test_contention();
    test_illegal();
    test_back_to_back();
    test_disabled();
    test_csr();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/router_4x4.md
# router_4x4

Four-port packet router (block `router_top`). Byte-wide packets enter on four source ports (`sa1`..`sa4`) and are forwarded whole to the destination port (`da1`..`da4`) named in the first byte. Each input has a single-packet store-and-forward buffer, and each output has a round-robin arbiter. A small CSR bus provides enable/clear control and per-port rx/tx/drop counters. The block sits between the packet sources and sinks and is driven by one clock.

## Interface
- DATA_W, 8, packet byte width
- BUF_DEPTH, 64, per-input packet buffer depth in bytes (maximum packet length)
- CSR_AW, 8, CSR address width
- CSR_DW, 32, CSR data width
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  asynchronous, active-high; clears all state
- sa1..sa4  in  DATA_W  source port byte
- sa1_valid..sa4_valid  in  1  high on every cycle that carries a byte of the current packet
- da1..da4  out  DATA_W  destination port byte
- da1_valid..da4_valid  out  1  high on every cycle that carries a forwarded byte
- wr  in  1  CSR write strobe
- rd  in  1  CSR read strobe
- addr  in  CSR_AW  CSR address
- wdata  in  CSR_DW  CSR write data
- rdata  out  CSR_DW  CSR read data

## Operation
- **Packet framing**
  - A packet is a maximal run of consecutive cycles with `saN_valid`=1.
  - Byte 0 is the destination address (DA); the remaining bytes are opaque.
  - Legal packets have DA in 1..4 and a length of 2..BUF_DEPTH bytes.
- **Input buffer** (one per port)
  - States: IDLE, RECV, HOLD, SEND.
  - IDLE→RECV when valid rises, provided the buffer is empty and CTRL.en=1.
  - RECV→HOLD when valid falls and the packet is legal.
  - HOLD raises a request to output DA; HOLD→SEND on grant.
  - SEND→IDLE after the last byte is sent.
- **Drop conditions** (packet discarded, `drop_count[N]` += 1, buffer back to IDLE)
  - DA equal to 0 or greater than 4.
  - Length below 2.
  - Length above BUF_DEPTH: the excess bytes are ignored, and the drop is counted when valid falls.
  - Packet starts while the buffer is not IDLE (the whole packet is discarded).
  - Packet starts while CTRL.en=0.
- **Output arbiter** (one per port)
  - Round-robin among requesting inputs. Priority starts after the last granted input; the reset order is 1,2,3,4.
  - A grant is held until the whole packet has been sent.
- **Forwarding**
  - Bytes are sent unmodified, in order, DA byte included, back-to-back with no gaps.
  - A self-addressed packet (DA equal to its own input port) is legal.
- **Counters**
  - `rx_count[N]` += 1 per legal packet received.
  - `tx_count[M]` += 1 per packet completed on output M.
  - All counters are 32-bit and wrap.
- **CSR map** (byte addresses)
  - 0x00 CTRL: bit0 `en` (reset 1); bit1 `clr`, write-1 clears all counters, self-clearing, reads 0.
  - 0x10..0x13 `rx_count[1..4]`.
  - 0x20..0x23 `tx_count[1..4]`.
  - 0x30..0x33 `drop_count[1..4]`.
  - Counters are read-only; writes to them are ignored. Unmapped reads return 0.
- **Clearing CTRL.en**
  - New packets are blocked.
  - Packets in RECV, HOLD or SEND complete normally.

## Timing
- **Reset values**: all `da*`=0, `da*_valid`=0, `rdata`=0, counters=0, CTRL=0x1, buffers IDLE.
- **Reset assertion**: outputs clear immediately, without waiting for a clock edge; a packet in flight is truncated.
- **Forwarding latency**: edge E samples `sa_valid`=0 after a legal packet. If the output is free, the first `da` byte is valid after edge E+2.
- **Output stream**: the last byte is followed by `da_valid`=0 for at least 1 cycle before the next packet on that output.
- **Simultaneous requests** to one output: served in round-robin order; the losers stay in HOLD.
- **CSR write**: takes effect at the edge sampling `wr`=1.
- **CSR read**
  - `rdata` is registered: the value is valid the cycle after the edge that samples `rd`=1, and holds until the next read.
  - With `wr` and `rd` both high, `rdata` returns the pre-write value.
- **Counter clear vs increment**: a clear and an increment on the same edge leave the counter at 0.

## Structure
- Package `router_pkg`: DATA_W, BUF_DEPTH, NPORTS=4, CSR address constants, input-buffer state enum.
- Sub-module `router_in_port`: buffer, framing/legality checks, request/grant handshake, rx/drop pulses.
- Arbiters, output muxes and CSR block live in the top.

## Test plan
- **Single packet**: reset, then `sa1` sends DA=3, 0xAA, 0x55 → `da3` carries 03,AA,55 starting 2 cycles after `sa1_valid` falls; `rx_count[1]`=1, `tx_count[3]`=1.
- **Contention**: `sa1` and `sa2` both end packets to DA=4 on the same cycle → `da4` sends `sa1`'s packet, a gap of ≥1 cycle, then `sa2`'s packet; the next contention grants `sa2` first.
- **Illegal packets**: DA=0, DA=7, a 1-byte packet and a 65-byte packet on `sa2` → nothing appears on any `da`; `drop_count[2]`=4.
- **Disabled router**: write CTRL=0, then send a packet on `sa4` → no output, `drop_count[4]`=1. Write CTRL=1, resend → delivered.
- **CSR behaviour**: read 0x10 → `rdata` valid 1 cycle later; write CTRL=0x3 → all counters read 0 and CTRL reads 0x1; unmapped address 0x50 reads 0.
- **Reset mid-packet**: assert `reset` mid-transmission → `da_valid` drops immediately; after release all counters are 0 and a new packet forwards normally.
